// File: rtl/sprite_blit_engine_pkg.sv
// Shared drawing constants and types for the sprite blit engine and its counter.
package draw_pkg;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 6;
    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_blit_engine_if.sv
// Draw command, sprite ROM and pixel-write bundle between datapath, engine and VGA adapter.
interface sprite_blit_engine_if;
    import draw_pkg::*;

    logic              start;
    logic [X_W-1:0]    x0;
    logic [Y_W-1:0]    y0;
    logic [X_W-1:0]    w;
    logic [Y_W-1:0]    h;
    colour_t           key;
    logic [ADDR_W-1:0] rom_addr;
    colour_t           rom_data;
    logic [X_W-1:0]    x_out;
    logic [Y_W-1:0]    y_out;
    colour_t           colour_out;
    logic              plot;
    logic              busy;
    logic              done;

    modport master (
        output start, x0, y0, w, h, key, rom_data,
        input  rom_addr, x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, w, h, key, rom_data,
        output rom_addr, x_out, y_out, colour_out, plot, busy, done
    );

endinterface

// File: rtl/sprite_blit_engine_scan.sv
// rect_scan_counter: row-major cx/cy/linear-address walker with last-pixel flag.
module rect_scan_counter #(
    parameter int unsigned CX_W = 8,
    parameter int unsigned CY_W = 7,
    parameter int unsigned A_W  = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_step,
    input  logic [CX_W-1:0] i_w,
    input  logic [CY_W-1:0] i_h,
    output logic [CX_W-1:0] o_cx,
    output logic [CY_W-1:0] o_cy,
    output logic [A_W-1:0]  o_addr,
    output logic            o_last
);

    logic [CX_W-1:0] r_cx;
    logic [CY_W-1:0] r_cy;
    logic [A_W-1:0]  r_addr;
    logic            w_col_end;
    logic            w_row_end;

    assign w_col_end = (r_cx == i_w - CX_W'(1));
    assign w_row_end = (r_cy == i_h - CY_W'(1));
    assign o_last    = w_col_end && w_row_end;
    assign o_cx      = r_cx;
    assign o_cy      = r_cy;
    assign o_addr    = r_addr;

    // Holding on the last pixel keeps the final address visible after the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_addr <= '0;
        end else if (i_clear) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_addr <= '0;
        end else if (i_step && !o_last) begin
            r_addr <= r_addr + A_W'(1);
            if (w_col_end) begin
                r_cx <= '0;
                r_cy <= r_cy + CY_W'(1);
            end else begin
                r_cx <= r_cx + CX_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blit_engine.sv
// Rectangle/sprite draw sequencer feeding the VGA adapter from a synchronous sprite ROM.
// Optional colour-key transparency: define SPRITE_BLIT_TRANSPARENCY_EN.
module sprite_blit_engine
    import draw_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    sprite_blit_engine_if.slave bus
);

    state_t            r_state;
    state_t            w_next;
    logic              w_load;
    logic              w_issue;
    logic              w_last;
    logic [X_W-1:0]    w_cx;
    logic [Y_W-1:0]    w_cy;
    logic [ADDR_W-1:0] w_addr;
    logic [X_W:0]      w_xs;
    logic [Y_W:0]      w_ys;
    logic              w_visible;

    logic [X_W-1:0]    r_x0;
    logic [Y_W-1:0]    r_y0;
    logic [X_W-1:0]    r_w;
    logic [Y_W-1:0]    r_h;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_plot;

    rect_scan_counter #(
        .CX_W (X_W),
        .CY_W (Y_W),
        .A_W  (ADDR_W)
    ) u_scan (
        .clk     (clock),
        .rst_n   (resetn),
        .i_clear (w_load),
        .i_step  (w_issue),
        .i_w     (r_w),
        .i_h     (r_h),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.w != '0) && (bus.h != '0)) begin
                        w_next = SWEEP;
                        w_load = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            SWEEP: begin
                w_issue = 1'b1;
                if (w_last) w_next = FLUSH;
            end
            FLUSH:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_w  <= '0;
            r_h  <= '0;
        end else if (w_load) begin
            r_x0 <= bus.x0;
            r_y0 <= bus.y0;
            r_w  <= bus.w;
            r_h  <= bus.h;
        end
    end

    // Extra sum bit so coordinates past the 8/7-bit range still register as off-screen.
    assign w_xs      = {1'b0, r_x0} + {1'b0, w_cx};
    assign w_ys      = {1'b0, r_y0} + {1'b0, w_cy};
    assign w_visible = (w_xs < (X_W+1)'(SCREEN_W)) && (w_ys < (Y_W+1)'(SCREEN_H));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x    <= '0;
            r_y    <= '0;
            r_plot <= 1'b0;
        end else begin
            r_plot <= w_issue && w_visible;
            if (w_issue) begin
                r_x <= w_xs[X_W-1:0];
                r_y <= w_ys[Y_W-1:0];
            end
        end
    end

    assign bus.rom_addr   = w_addr;
    assign bus.x_out      = r_x;
    assign bus.y_out      = r_y;
    assign bus.colour_out = bus.rom_data;
    assign bus.busy       = (r_state == SWEEP) || (r_state == FLUSH);
    assign bus.done       = (r_state == DONE);

`ifdef SPRITE_BLIT_TRANSPARENCY_EN
    colour_t r_key;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     r_key <= '0;
        else if (w_load) r_key <= bus.key;
    end

    // Key test runs on the ROM word aligned with the registered pixel.
    assign bus.plot = r_plot && (bus.rom_data != r_key);
`else
    assign bus.plot = r_plot;
`endif

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed self-checking bench for sprite_blit_engine with a synchronous ROM model.
module tb_sprite_blit_engine;
    import draw_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   p, c, r, nplot, ndone;
    logic [3:0] exp_pat;

    sprite_blit_engine_if bus();

    sprite_blit_engine dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    function automatic colour_t rom_fn(input logic [ADDR_W-1:0] a);
        logic [4:0] lo;
        lo = a[4:0];
        return (a == ADDR_W'(2)) ? 6'h3F : {lo, 1'b1};
    endfunction

    always @(posedge clock) bus.rom_data <= rom_fn(bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0; bus.key = '0;
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
        exp_pat = 4'b1011;
`else
        exp_pat = 4'b1111;
`endif
        // Reset state
        tick(); tick();
        check("rst_rom_addr", 32'(bus.rom_addr), 0);
        check("rst_x_out", 32'(bus.x_out), 0);
        check("rst_y_out", 32'(bus.y_out), 0);
        check("rst_plot", 32'(bus.plot), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        resetn = 1'b1;
        tick();

        // 3x2 at (10,20)
        bus.x0 = 8'd10; bus.y0 = 7'd20; bus.w = 8'd3; bus.h = 7'd2; bus.start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) begin bus.start = 1'b0; bus.x0 = 8'd99; bus.w = 8'd1; end
            if (k >= 2 && k <= 7) begin
                p = k - 2;
                check("t1_plot", 32'(bus.plot), 1);
                check("t1_x", 32'(bus.x_out), 32'(10 + p % 3));
                check("t1_y", 32'(bus.y_out), 32'(20 + p / 3));
                check("t1_colour", 32'(bus.colour_out), 32'(rom_fn(ADDR_W'(p))));
            end else begin
                check("t1_plot_idle", 32'(bus.plot), 0);
            end
            if (k <= 7) check("t1_rom_addr", 32'(bus.rom_addr), 32'((k <= 6) ? k - 1 : 5));
            check("t1_done", 32'(bus.done), 32'(k == 8));
            check("t1_busy", 32'(bus.busy), 32'(k <= 7));
        end

        // Clipping at bottom-right corner
        bus.x0 = 8'd158; bus.y0 = 7'd118; bus.w = 8'd4; bus.h = 7'd4; bus.start = 1'b1;
        nplot = 0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 1) bus.start = 1'b0;
            if (k >= 2 && k <= 17) begin
                p = k - 2; c = p % 4; r = p / 4;
                check("t2_plot", 32'(bus.plot), 32'((158 + c < 160) && (118 + r < 120)));
                check("t2_x", 32'(bus.x_out), 32'(158 + c));
                check("t2_y", 32'(bus.y_out), 32'(118 + r));
            end else begin
                check("t2_plot_idle", 32'(bus.plot), 0);
            end
            if (bus.plot === 1'b1) nplot++;
            check("t2_done", 32'(bus.done), 32'(k == 18));
        end
        check("t2_plot_count", 32'(nplot), 4);

        // Zero-width command
        bus.x0 = 8'd5; bus.y0 = 7'd5; bus.w = 8'd0; bus.h = 7'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t3_done", 32'(bus.done), 1);
        check("t3_busy", 32'(bus.busy), 0);
        check("t3_plot", 32'(bus.plot), 0);
        tick();
        check("t3_done_end", 32'(bus.done), 0);
        check("t3_busy_end", 32'(bus.busy), 0);
        check("t3_plot_end", 32'(bus.plot), 0);

        // Starts mid-sweep and in DONE ignored; start in following IDLE accepted
        bus.x0 = 8'd30; bus.y0 = 7'd40; bus.w = 8'd2; bus.h = 7'd2; bus.start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
            check("t4_done", 32'(bus.done), 32'(k == 6 || k == 10));
            check("t4_busy", 32'(bus.busy), 32'((k <= 5) || k == 8 || k == 9));
            if (k >= 2 && k <= 5) begin
                check("t4_plot", 32'(bus.plot), 1);
                check("t4_x", 32'(bus.x_out), 32'(30 + (k - 2) % 2));
                check("t4_y", 32'(bus.y_out), 32'(40 + (k - 2) / 2));
            end
            if (k == 7) check("t4_addr_hold", 32'(bus.rom_addr), 3);
            if (k == 8) check("t4_addr_restart", 32'(bus.rom_addr), 0);
            if (k == 9) begin
                check("t4_plot2", 32'(bus.plot), 1);
                check("t4_x2", 32'(bus.x_out), 5);
            end
            if (k == 1) bus.start = 1'b0;
            if (k == 3) begin bus.start = 1'b1; bus.w = 8'd1; bus.h = 7'd1; bus.x0 = 8'd5; end
            if (k == 4) bus.start = 1'b0;
            if (k == 6) bus.start = 1'b1;
            if (k == 7) bus.start = 1'b1;
            if (k == 8) bus.start = 1'b0;
        end
        check("t4_done_count", 32'(ndone), 2);

        // Reset mid-sweep of a 64x42 sprite
        bus.x0 = 8'd0; bus.y0 = 7'd0; bus.w = 8'd64; bus.h = 7'd42; bus.start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) bus.start = 1'b0;
        end
        check("t5_plot_pre", 32'(bus.plot), 1);
        check("t5_x_pre", 32'(bus.x_out), 7);
        resetn = 1'b0;
        #1;
        check("t5_plot_async", 32'(bus.plot), 0);
        check("t5_busy_async", 32'(bus.busy), 0);
        check("t5_done_async", 32'(bus.done), 0);
        check("t5_addr_async", 32'(bus.rom_addr), 0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        resetn = 1'b1;
        tick();
        if (bus.done === 1'b1) ndone++;
        check("t5_no_done", 32'(ndone), 0);
        bus.x0 = 8'd3; bus.y0 = 7'd4; bus.w = 8'd2; bus.h = 7'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t5_busy_new", 32'(bus.busy), 1);
        check("t5_addr_new", 32'(bus.rom_addr), 0);
        tick();
        check("t5_plot_new", 32'(bus.plot), 1);
        check("t5_x_new", 32'(bus.x_out), 3);
        check("t5_y_new", 32'(bus.y_out), 4);
        check("t5_colour_new", 32'(bus.colour_out), 32'(6'h01));
        tick();
        check("t5_x_new2", 32'(bus.x_out), 4);
        tick();
        check("t5_done_new", 32'(bus.done), 1);
        tick();

        // 4x1 sprite with key 6'h3F at ROM word 2
        bus.x0 = 8'd0; bus.y0 = 7'd0; bus.w = 8'd4; bus.h = 7'd1; bus.key = 6'h3F; bus.start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) bus.start = 1'b0;
            if (k >= 2 && k <= 5) begin
                check("t6_plot", 32'(bus.plot), 32'(exp_pat[k - 2]));
                check("t6_x", 32'(bus.x_out), 32'(k - 2));
            end
            if (k == 4) check("t6_colour_key", 32'(bus.colour_out), 32'(6'h3F));
            check("t6_done", 32'(bus.done), 32'(k == 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_blit_engine.md
Name: sprite_blit_engine

Overview:
- Rectangle/sprite draw sequencer sitting directly downstream of the battle datapath and directly upstream of the VGA adapter.
- The datapath issues one draw command (origin, size, ROM selection already applied externally). The engine sweeps the rectangle row-major and fetches colours from a synchronous sprite ROM.
- It emits x/y/colour/plot pixel writes and returns a one-cycle done pulse. The control FSM uses that pulse as its *_done signals (menu_done, drawSelectP1_done, etc.).

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 6, colour width (2 bits/channel)
- ADDR_W, 14, sprite ROM address width
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- x0  in  X_W  rectangle origin x
- y0  in  Y_W  rectangle origin y
- w  in  X_W  rectangle width, 0..255
- h  in  Y_W  rectangle height, 0..127
- key  in  COLOUR_W  transparent colour (used only with TRANSPARENCY_EN)
- rom_addr  out  ADDR_W  linear sprite index, row-major
- rom_data  in  COLOUR_W  ROM output, valid one cycle after rom_addr
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour_out  out  COLOUR_W  pixel colour, equal to rom_data
- plot  out  1  pixel write enable to the VGA adapter
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, resetn=0): state=IDLE; rom_addr, x_out, y_out = 0; plot, busy, done = 0; internal counters and latched command = 0.
- States: IDLE, SWEEP, FLUSH, DONE.
- IDLE:
  - start=1 with w!=0 and h!=0: latch x0, y0, w, h, key; cx=cy=0, addr=0; go to SWEEP.
  - start=1 with w==0 or h==0: go straight to DONE; no plot is ever asserted.
- SWEEP:
  - Each cycle, rom_addr = addr, then addr increments.
  - cx increments; when cx==w-1, cx wraps to 0 and cy increments.
  - Addresses beyond 2^ADDR_W wrap modulo 2^ADDR_W.
  - After the cycle that issues (cx=w-1, cy=h-1), go to FLUSH.
- Pixel stage (one register stage):
  - x_out <= x0+cx and y_out <= y0+cy, registered alongside each issued address.
  - plot <= 1 for each issued address unless the pixel is clipped.
  - Clipping: sums are computed at X_W+1 / Y_W+1 bits; plot=0 if x sum >= SCREEN_W or y sum >= SCREEN_H. x_out/y_out carry the truncated sum.
  - colour_out is combinationally equal to rom_data, so it aligns with the registered x_out/y_out/plot.
- FLUSH: the last pixel is presented; no new address is issued; go to DONE.
- DONE: done=1 and plot=0 for exactly one cycle; go to IDLE.
- busy: high in SWEEP and FLUSH, low in IDLE and DONE.
- Latency: start accepted at cycle T; first pixel at T+2; last pixel at T+w*h+1; done at T+w*h+2. Total w*h pixel cycles.
- start while not in IDLE is ignored (no queueing). Changes to x0/y0/w/h/key after acceptance have no effect.
- A start in the DONE cycle is ignored; it is accepted only in IDLE, i.e. the cycle after done.
- resetn asserted mid-sweep: immediate return to IDLE, plot=0 asynchronously, no done pulse.
- Outside SWEEP/FLUSH, plot=0 and rom_addr holds its last value.

Optional Feature:
- Macro: SPRITE_BLIT_TRANSPARENCY_EN.
- Defined: a pixel with rom_data==key has plot=0, so the background shows through. x_out/y_out still advance and timing is unchanged.
- Undefined: key is ignored and every unclipped pixel plots.

Decomposition:
- Shared package draw_pkg:
  - X_W, Y_W, COLOUR_W, SCREEN_W, SCREEN_H constants
  - state enum typedef for IDLE/SWEEP/FLUSH/DONE
  - typedef for the colour type
- Natural sub-module: rect_scan_counter (cx/cy/addr generator with wrap and last-pixel flag), reusable for full-screen and message-box sweeps.

Test Plan:
- w=3, h=2 at (10,20), start at T: plots at T+2..T+7 for (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); rom_addr 0..5; done only at T+8.
- x0=158, y0=118, w=4, h=4: 16 pixel cycles; plot high only for x∈{158,159}, y∈{118,119} (4 pixels); done at T+18.
- w=0, h=5: done at T+1 (one cycle), plot never high, busy never high.
- Second start pulsed mid-sweep and again in the DONE cycle: both ignored; exactly one done per accepted command; a start in the following IDLE cycle is accepted.
- resetn pulled low at pixel 7 of a 64x42 sprite: plot, busy, done go to 0 immediately; no done pulse; a fresh start after release draws from rom_addr 0.
- With SPRITE_BLIT_TRANSPARENCY_EN, key=6'h3F, ROM word 2 = 6'h3F on a 4x1 sprite: plot pattern 1,1,0,1. Without the macro: 1,1,1,1.
